// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer (drives enables/selects), slave = datapath/memory side.
interface multicycle_control_if #(
  parameter int CNT_WIDTH = 32
);
  logic [5:0]           opcode;
  logic                 Zero;
  logic                 MemReady;
  logic                 PCEn;
  logic                 IorD;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegDst;
  logic                 MemtoReg;
  logic                 RegWrite;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ALUOp;
  logic [1:0]           PCSource;
  logic                 Retire;
  logic [CNT_WIDTH-1:0] InstrCount;
  logic                 BusError;
  logic                 Halted;
  logic [3:0]           State;

  modport master (
    input  opcode, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Retire, InstrCount, BusError,
           Halted, State
  );

  modport slave (
    output opcode, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Retire, InstrCount, BusError,
           Halted, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath: fetch/decode/execute/mem/writeback,
// stalls on MemReady, halts on illegal opcode or memory timeout, counts retired instructions.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11,
    HALT     = 4'd15
  } state_t;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t               r_state, w_next;
  logic [TW-1:0]        r_tmo_cnt;
  logic [CNT_WIDTH-1:0] r_instr_cnt;

  logic       w_pcen, w_iord, w_memread, w_memwrite, w_irwrite, w_regdst;
  logic       w_memtoreg, w_regwrite, w_alusrca, w_retire, w_buserr, w_halted;
  logic [1:0] w_alusrcb, w_aluop, w_pcsource;
  logic       w_mem_state, w_tmo_hit;

  assign w_mem_state = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);
  assign w_tmo_hit   = (MEM_TIMEOUT != 0) && w_mem_state && !bus.MemReady &&
                       (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= FETCH;
      r_tmo_cnt   <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_mem_state && !bus.MemReady && !w_tmo_hit)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else
        r_tmo_cnt <= '0;
      if (w_retire)
        r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pcen     = 1'b0;
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsource = 2'b00;
    w_retire   = 1'b0;
    w_buserr   = 1'b0;
    w_halted   = 1'b0;
    case (r_state)
      FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = bus.MemReady;
        w_pcen    = bus.MemReady;
        if (bus.MemReady) w_next = DECODE;
      end
      DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.opcode)
          6'd0:         w_next = EXECUTE;
          6'd35, 6'd43: w_next = MEMADR;
          6'd4, 6'd5:   w_next = BRANCH;
          6'd2:         w_next = JUMP;
          6'd8:         w_next = ADDIEX;
          default:      w_next = HALT;
        endcase
      end
      MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.opcode == 6'd43) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        if (bus.MemReady) w_next = MEMWB;
      end
      MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      MEMWRITE: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_retire   = bus.MemReady;
        if (bus.MemReady) w_next = FETCH;
      end
      EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = ALUWB;
      end
      ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      BRANCH: begin
        // bne (5) takes the branch on a nonzero difference, beq on zero
        w_alusrca  = 1'b1;
        w_aluop    = 2'b01;
        w_pcsource = 2'b01;
        w_retire   = 1'b1;
        w_pcen     = (bus.opcode == 6'd5) ? !bus.Zero : bus.Zero;
        w_next     = FETCH;
      end
      JUMP: begin
        w_pcsource = 2'b10;
        w_pcen     = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = ADDIWB;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = FETCH;
      end
      HALT: begin
        w_halted = 1'b1;
      end
      default: w_next = HALT;
    endcase
    // Timeout overrides the stall; a completing access in the same cycle never reaches here
    if (w_tmo_hit) begin
      w_buserr = 1'b1;
      w_next   = HALT;
    end
  end

  assign bus.PCEn       = !RESET && w_pcen;
  assign bus.IorD       = !RESET && w_iord;
  assign bus.MemRead    = !RESET && w_memread;
  assign bus.MemWrite   = !RESET && w_memwrite;
  assign bus.IRWrite    = !RESET && w_irwrite;
  assign bus.RegDst     = !RESET && w_regdst;
  assign bus.MemtoReg   = !RESET && w_memtoreg;
  assign bus.RegWrite   = !RESET && w_regwrite;
  assign bus.ALUSrcA    = !RESET && w_alusrca;
  assign bus.ALUSrcB    = RESET ? 2'b00 : w_alusrcb;
  assign bus.ALUOp      = RESET ? 2'b00 : w_aluop;
  assign bus.PCSource   = RESET ? 2'b00 : w_pcsource;
  assign bus.Retire     = !RESET && w_retire;
  assign bus.BusError   = !RESET && w_buserr;
  assign bus.Halted     = !RESET && w_halted;
  assign bus.InstrCount = RESET ? '0 : r_instr_cnt;
  assign bus.State      = RESET ? 4'd0 : 4'(r_state);

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencing controller for the MIPS datapath (PC, instruction/data memory, register file, ALU, sign-extend/shift, muxes). It replaces the single-cycle opcode decoder with a Moore FSM. The FSM steps each instruction through fetch, decode, execute, memory and writeback. It stalls on a memory ready handshake, halts on illegal opcodes or memory timeout, and counts retired instructions. It sits between the instruction register opcode field, the ALU Zero flag and all datapath enables/mux selects.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready cycles in a memory state before bus error; 0 disables the timeout
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
CLK  input  1  clock, all state changes on rising edge
RESET  input  1  synchronous, active-high reset
opcode  input  6  instruction bits [31:26] from the instruction register
Zero  input  1  ALU zero flag, sampled combinationally in BRANCH
MemReady  input  1  memory access completes this cycle
PCEn  output  1  PC load enable
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
RegDst  output  1  write register select: 0 = rt, 1 = rd
MemtoReg  output  1  write data select: 0 = ALUOut, 1 = memory data
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
ALUOp  output  2  to ALU controller: 00 = add, 01 = subtract, 10 = use funct
PCSource  output  2  next PC select: 00 = ALU, 01 = ALUOut (branch target), 10 = jump target
Retire  output  1  one-cycle pulse when an instruction completes
InstrCount  output  CNT_WIDTH  retired-instruction count
BusError  output  1  one-cycle pulse on memory timeout
Halted  output  1  FSM is in HALT
State  output  4  current state code for debug

Behaviour:
- Reset: on a rising CLK edge with RESET=1, the state becomes FETCH, InstrCount becomes 0 and the timeout counter becomes 0. While RESET=1, every output is forced to 0 combinationally, State included. Reset mid-instruction abandons that instruction; no partial write is issued after the reset edge.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite and PCEn equal MemReady. If MemReady=1, go to DECODE; otherwise stay.
- DECODE: ALUSrcB=11. Next state by opcode:
  - 0 -> EXECUTE
  - 35 or 43 -> MEMADR
  - 4 or 5 -> BRANCH
  - 2 -> JUMP
  - 8 -> ADDIEX
  - any other opcode -> HALT
- MEMADR: ALUSrcA=1, ALUSrcB=10. Opcode 35 -> MEMREAD; opcode 43 -> MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Wait for MemReady, then go to MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, Retire=1. Next state FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Wait for MemReady. In the MemReady cycle: Retire=1, next state FETCH.
- EXECUTE: ALUSrcA=1, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1, Retire=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, Retire=1. PCEn = Zero for opcode 4, ~Zero for opcode 5. Next state FETCH.
- JUMP: PCSource=10, PCEn=1, Retire=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next state ADDIWB.
- ADDIWB: RegWrite=1, Retire=1. Next state FETCH.
- HALT: Halted=1, all strobes 0. The FSM stays in HALT until RESET.
- Latency from FETCH entry with MemReady always 1, in cycles:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j: 3
  - addi: 4
- Memory handshake:
  - Applies in FETCH, MEMREAD and MEMWRITE.
  - Strobes are held stable every waiting cycle.
  - The timeout counter increments on each cycle in one of these states with MemReady=0, and clears on MemReady=1 or on leaving the state.
  - When MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with MemReady=0, the FSM pulses BusError and goes to HALT.
  - If MemReady=1 in that same cycle, the normal transition wins and there is no BusError.
- InstrCount increments by 1 on each Retire and wraps modulo 2^CNT_WIDTH.

Test Plan:
- Sequence add, lw, sw, beq, j, addi with MemReady tied to 1 -> states 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9 / 0,1,10,11; InstrCount=6 at the end.
- beq with Zero=1 and Zero=0, then bne with Zero=1 and Zero=0 -> PCEn in BRANCH is 1, 0, 0, 1 respectively, with PCSource=01 each time.
- lw with MemReady low for 3 cycles in MEMREAD -> MemRead=1, IorD=1 held for 4 cycles; RegWrite only in the following MEMWB; no BusError.
- MEM_TIMEOUT=4, MemReady held 0 in FETCH -> BusError pulses on the 4th waiting cycle, then State=15 and Halted=1 persist. Repeat with MemReady=1 on the 4th cycle -> DECODE, no BusError.
- opcode 63 in DECODE -> HALT, no Retire, InstrCount unchanged. RESET pulse -> State=0, InstrCount=0.
- RESET asserted during MEMWRITE wait -> all outputs 0 while RESET=1, MemWrite never reasserts, FETCH on the next edge.
